alu_cmd_sequencer: RTL

Upstream command stage for the ALU/controller top level. It buffers ALU commands (a, b, op) arriving on a valid/ready interface in a small FIFO. For each command it issues one `start` pulse to the controller, holds the operands stable for a fixed number of cycles, and captures `result`/`flag` into a valid/ready output register. It lets a producer queue operations back-to-back without tracking controller timing.

---
 rtl/alu_cmd_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/wait/hold sequencer in front of the ALU controller.
// Optional build macro ALU_SEQ_COUNT_EN adds a saturating output-handshake counter (op_count).
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_a,
    input  logic [5:0] in_b,
    input  logic [1:0] in_op,
    output logic       start,
    output logic [5:0] a,
    output logic [5:0] b,
    output logic [1:0] op,
    input  logic [5:0] result,
    input  logic       flag,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_result,
`ifdef ALU_SEQ_COUNT_EN
    output logic       out_flag,
    output logic [7:0] op_count
`else
    output logic       out_flag
`endif
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = PW + 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic               full_q, full_d;
    logic               empty;
    logic               push, pop, capture, release_out;
    logic [13:0]        mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign in_ready = !full_q;
    assign push     = in_valid && !full_q;
    assign start    = (state_q == ISSUE);

    assign wr_ptr_d = wr_ptr + PTR_W'(push);
    assign rd_ptr_d = rd_ptr + PTR_W'(pop);
    // Full is registered from the next pointers so in_ready never depends on a same-cycle pop.
    assign full_d   = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                      (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            full_q     <= 1'b0;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flag   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_ptr  <= wr_ptr_d;
            rd_ptr  <= rd_ptr_d;
            full_q  <= full_d;
            if (pop) begin
                {a, b, op} <= mem[rd_ptr[PW-1:0]];
            end
            if (capture) begin
                out_result <= result;
                out_flag   <= flag;
                out_valid  <= 1'b1;
            end else if (release_out) begin
                out_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {in_a, in_b, in_op};
        end
    end

`ifdef ALU_SEQ_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (out_valid && out_ready && op_count != 8'hFF) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif

endmodule
